// File: rtl/dmux_stream_pkg.sv
// Shared definitions for the stream demultiplexer: channel-count ceiling and
// the select range check used by the top-level decode.
package dmux_stream_pkg;

  localparam int DMUX_MAX_N = 16;

  // A select is out of range when it names no instantiated channel.
  function automatic logic sel_oor(input int unsigned s, input int unsigned n);
    return (s >= n) || (s >= DMUX_MAX_N);
  endfunction

endpackage

// File: rtl/dmux_slot.sv
// One-entry output holding register. A load always wins over a drain, so a
// slot that drains and reloads on the same edge stays valid with the new word.
module dmux_slot #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] d,
  input  logic         ready,
  output logic [W-1:0] q,
  output logic         valid,
  output logic         free
);

  assign free = ~valid | ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q     <= '0;
      valid <= 1'b0;
    end else if (load) begin
      q     <= d;
      valid <= 1'b1;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/dmux_stream.sv
// Registered 1-to-N stream demultiplexer: unicast by sel or broadcast to all
// channels, one holding slot per channel, err pulse on dropped out-of-range words.
module dmux_stream
  import dmux_stream_pkg::*;
#(
  parameter int W  = 32,
  parameter int N  = 4,
  parameter int SW = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [W-1:0]   din,
  input  logic [SW-1:0]  sel,
  input  logic           bcast,
  input  logic           din_valid,
  output logic           din_ready,
  output logic [N*W-1:0] dout,
  output logic [N-1:0]   dout_valid,
  input  logic [N-1:0]   dout_ready,
  output logic           err
);

  logic [N-1:0][W-1:0] q;
  logic [N-1:0]        free;
  logic [N-1:0]        hit;
  logic [N-1:0]        load;
  logic                oor;
  logic                accept;

  assign oor    = sel_oor(32'(sel), N);
  assign accept = din_valid & din_ready;

  // Out-of-range words are swallowed, so they never stall the producer.
  assign din_ready = bcast ? &free : (oor ? 1'b1 : |(free & hit));

  for (genvar k = 0; k < N; k++) begin : g_slot
    assign hit[k]  = (sel == SW'(k));
    assign load[k] = accept & (bcast | hit[k]);

    dmux_slot #(.W(W)) u_slot (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load[k]),
      .d     (din),
      .ready (dout_ready[k]),
      .q     (q[k]),
      .valid (dout_valid[k]),
      .free  (free[k])
    );
  end

  assign dout = q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err <= 1'b0;
    else        err <= accept & ~bcast & oor;
  end

endmodule

// File: tb/tb_dmux_stream.sv
// Directed bench for dmux_stream: vector table on a 4-channel instance, plus
// reset, out-of-range and throughput sequences (3- and 4-channel instances).
module tb_dmux_stream;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 4-channel instance
  logic [31:0]  din4 = '0;
  logic [1:0]   sel4 = '0;
  logic         bc4 = 1'b0, dv4 = 1'b0, dr4, err4;
  logic [127:0] dout4;
  logic [3:0]   ov4, ordy4 = '0;

  // 3-channel instance (sel = 3 is out of range)
  logic [31:0]  din3 = '0;
  logic [1:0]   sel3 = '0;
  logic         bc3 = 1'b0, dv3 = 1'b0, dr3, err3;
  logic [95:0]  dout3;
  logic [2:0]   ov3, ordy3 = '0;

  dmux_stream #(.W(32), .N(4), .SW(2)) u4 (
    .clk(clk), .rst_n(rst_n), .din(din4), .sel(sel4), .bcast(bc4),
    .din_valid(dv4), .din_ready(dr4), .dout(dout4), .dout_valid(ov4),
    .dout_ready(ordy4), .err(err4)
  );

  dmux_stream #(.W(32), .N(3), .SW(2)) u3 (
    .clk(clk), .rst_n(rst_n), .din(din3), .sel(sel3), .bcast(bc3),
    .din_valid(dv3), .din_ready(dr3), .dout(dout3), .dout_valid(ov3),
    .dout_ready(ordy3), .err(err3)
  );

  int total = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h want %0h", name, act, exp);
    else passed++;
  endtask

  typedef struct {
    logic [31:0] din;
    logic [1:0]  sel;
    logic        bc;
    logic        dv;
    logic [3:0]  ordy;
    logic        rdy;   // expected din_ready before the edge
    logic [3:0]  ov;    // expected dout_valid after the edge
    int          ch;    // channel whose data is checked after the edge
    logic [31:0] data;
  } vec_t;

  vec_t vt[15];
  logic [31:0] sbq[4][$];

  initial begin
    int accepts;
    logic [1:0]  psel;
    logic [31:0] pdin;
    logic [31:0] exp_w;

    vt[0]  = '{32'hA5A5_0001, 2'd2, 1'b0, 1'b1, 4'b1111, 1'b1, 4'b0100, 2, 32'hA5A5_0001};
    vt[1]  = '{32'h1111_0001, 2'd1, 1'b0, 1'b1, 4'b1101, 1'b1, 4'b0010, 1, 32'h1111_0001};
    vt[2]  = '{32'h1111_0002, 2'd1, 1'b0, 1'b1, 4'b1101, 1'b0, 4'b0010, 1, 32'h1111_0001};
    vt[3]  = '{32'h1111_0002, 2'd1, 1'b0, 1'b1, 4'b1111, 1'b1, 4'b0010, 1, 32'h1111_0002};
    vt[4]  = '{32'h0000_0000, 2'd0, 1'b0, 1'b0, 4'b1111, 1'b1, 4'b0000, 1, 32'h1111_0002};
    vt[5]  = '{32'h3333_0003, 2'd3, 1'b0, 1'b1, 4'b0111, 1'b1, 4'b1000, 3, 32'h3333_0003};
    vt[6]  = '{32'hDEAD_BEEF, 2'd0, 1'b1, 1'b1, 4'b0111, 1'b0, 4'b1000, 3, 32'h3333_0003};
    vt[7]  = '{32'hDEAD_BEEF, 2'd0, 1'b1, 1'b1, 4'b1111, 1'b1, 4'b1111, 3, 32'hDEAD_BEEF};
    vt[8]  = '{32'h0000_0000, 2'd0, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b1111, 0, 32'hDEAD_BEEF};
    vt[9]  = '{32'h0000_0000, 2'd1, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b1111, 1, 32'hDEAD_BEEF};
    vt[10] = '{32'h0000_0000, 2'd2, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b1111, 2, 32'hDEAD_BEEF};
    vt[11] = '{32'h0000_0000, 2'd0, 1'b1, 1'b0, 4'b1111, 1'b1, 4'b0000, 2, 32'hDEAD_BEEF};
    vt[12] = '{32'h4444_0000, 2'd0, 1'b0, 1'b1, 4'b0000, 1'b1, 4'b0001, 0, 32'h4444_0000};
    vt[13] = '{32'h5555_0000, 2'd0, 1'b0, 1'b1, 4'b0000, 1'b0, 4'b0001, 0, 32'h4444_0000};
    vt[14] = '{32'h6666_0002, 2'd2, 1'b0, 1'b1, 4'b0000, 1'b1, 4'b0101, 2, 32'h6666_0002};

    // reset state
    #2;
    chk("rst_ov4", 128'(ov4), 128'(0));
    chk("rst_dout4", 128'(dout4), 128'(0));
    chk("rst_err3", 128'(err3), 128'(0));
    @(negedge clk); rst_n = 1'b1;

    // mid-stream asynchronous reset
    ordy4 = 4'b1111; dv4 = 1'b1; ordy3 = 3'b111; dv3 = 1'b1; sel3 = 2'd3;
    for (int i = 0; i < 3; i++) begin
      din4 = 32'hC0DE_0000 + 32'(i); sel4 = 2'(i);
      @(negedge clk);
    end
    chk("pre_rst_err3", 128'(err3), 128'(1));
    chk("pre_rst_ov4", 128'(ov4), 128'(4'b0100));
    #2 rst_n = 1'b0;
    #1;
    chk("async_ov4", 128'(ov4), 128'(0));
    chk("async_dout4", 128'(dout4), 128'(0));
    chk("async_err4", 128'(err4), 128'(0));
    chk("async_ov3", 128'(ov3), 128'(0));
    chk("async_dout3", 128'(dout3), 128'(0));
    chk("async_err3", 128'(err3), 128'(0));
    dv4 = 1'b0; dv3 = 1'b0; sel3 = '0;
    @(negedge clk); rst_n = 1'b1;

    // vector table
    for (int i = 0; i < 15; i++) begin
      din4 = vt[i].din; sel4 = vt[i].sel; bc4 = vt[i].bc;
      dv4 = vt[i].dv; ordy4 = vt[i].ordy;
      #1 chk($sformatf("v%0d_rdy", i), 128'(dr4), 128'(vt[i].rdy));
      @(negedge clk);
      chk($sformatf("v%0d_ov", i), 128'(ov4), 128'(vt[i].ov));
      chk($sformatf("v%0d_data", i), 128'(dout4[vt[i].ch*32 +: 32]), 128'(vt[i].data));
      chk($sformatf("v%0d_err", i), 128'(err4), 128'(0));
    end
    dv4 = 1'b0; bc4 = 1'b0;

    // out of range on the 3-channel instance
    din3 = 32'h7777_0000; sel3 = 2'd0; dv3 = 1'b1; ordy3 = 3'b000;
    @(negedge clk);
    chk("oor_pre_ov3", 128'(ov3), 128'(3'b001));
    din3 = 32'h9999_9999; sel3 = 2'd3;
    #1 chk("oor_rdy", 128'(dr3), 128'(1));
    @(negedge clk);
    dv3 = 1'b0;
    chk("oor_err_hi", 128'(err3), 128'(1));
    chk("oor_ov3", 128'(ov3), 128'(3'b001));
    chk("oor_dout3", 128'(dout3), 128'({64'h0, 32'h7777_0000}));
    @(negedge clk);
    chk("oor_err_lo", 128'(err3), 128'(0));
    chk("oor_ov3_hold", 128'(ov3), 128'(3'b001));
    // broadcast ignores an out-of-range sel
    bc3 = 1'b1; dv3 = 1'b1; ordy3 = 3'b111; din3 = 32'hBBBB_0003;
    #1 chk("oor_bc_rdy", 128'(dr3), 128'(1));
    @(negedge clk);
    bc3 = 1'b0; dv3 = 1'b0;
    chk("oor_bc_ov3", 128'(ov3), 128'(3'b111));
    chk("oor_bc_err", 128'(err3), 128'(0));
    chk("oor_bc_dout3", 128'(dout3), 128'({3{32'hBBBB_0003}}));

    // throughput with per-channel scoreboard
    ordy4 = 4'b1111; @(negedge clk);
    accepts = 0;
    for (int i = 0; i <= 1000; i++) begin
      if (i > 0) begin
        chk("tp_ov", 128'(ov4), 128'(4'b0001 << psel));
        for (int k = 0; k < 4; k++) begin
          if (ov4[k]) begin
            if (sbq[k].size() == 0) begin
              chk($sformatf("tp_extra_ch%0d", k), 128'(1), 128'(0));
            end else begin
              exp_w = sbq[k].pop_front();
              chk($sformatf("tp_data_ch%0d", k), 128'(dout4[k*32 +: 32]), 128'(exp_w));
            end
          end
        end
      end
      if (i < 1000) begin
        pdin = $urandom; psel = 2'($urandom_range(0, 3));
        din4 = pdin; sel4 = psel; dv4 = 1'b1;
        #1;
        if (dr4) begin
          accepts++;
          sbq[psel].push_back(pdin);
        end
        @(negedge clk);
      end
    end
    dv4 = 1'b0;
    chk("tp_accepts", 128'(accepts), 128'(1000));
    for (int k = 0; k < 4; k++)
      chk($sformatf("tp_empty_ch%0d", k), 128'(sbq[k].size()), 128'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
